// File: rtl/digit_scan_mux_if.sv
// digit_scan_mux_if
// Bundles the value handshake and the display-side outputs of digit_scan_mux.
//   load_in        : load strobe from the producer, accepted only while ready_out=1
//   value_in[15:0] : hex value, value_in[3:0] is the rightmost digit
//   ready_out      : high while the pending buffer is empty
//   nibble_out[3:0]: nibble for the active digit, feeds the seven-segment decoder
//   an_out[3:0]    : active-low digit enables, an_out[k] drives digit k
//   frame_done_out : one-cycle pulse on every frame wrap
// Modports: master = producer/display side, slave = scan controller.
interface digit_scan_mux_if;
  logic        load_in;
  logic [15:0] value_in;
  logic        ready_out;
  logic [3:0]  nibble_out;
  logic [3:0]  an_out;
  logic        frame_done_out;

  modport master (
    output load_in,
    output value_in,
    input  ready_out,
    input  nibble_out,
    input  an_out,
    input  frame_done_out
  );

  modport slave (
    input  load_in,
    input  value_in,
    output ready_out,
    output nibble_out,
    output an_out,
    output frame_done_out
  );
endinterface

// File: rtl/digit_scan_mux.sv
// digit_scan_mux
// Time-multiplexed 4-digit scan controller placed in front of a seven-segment
// decoder. A 16-bit value enters a pending buffer through a ready/load
// handshake and is committed to the displayed register only at a frame wrap,
// so one frame never mixes old and new digits.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : digit_scan_mux_if.slave (load_in, value_in, ready_out,
//           nibble_out, an_out, frame_done_out)
// Parameter:
//   SCAN_DIV : clock cycles per digit slot, legal 2..65535
// Optional build macro:
//   LEADING_ZERO_BLANK_EN : blank digits 1..3 while they and every more
//                           significant nibble are zero (digit 0 always lit)
module digit_scan_mux #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  digit_scan_mux_if.slave bus
);

  localparam logic [15:0] PC_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] pc_q, pc_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [3:0]  nibble_q, nibble_d;
  logic [3:0]  an_q, an_d;
  logic        frame_done_q, frame_done_d;

  logic        tick;
  logic        wrap;
  logic        accept;
  logic [15:0] disp_shift;
  logic        blank;

  assign tick   = (pc_q == PC_LAST);
  assign wrap   = tick && (idx_q == 2'd3);
  assign accept = bus.load_in && !pend_v_q;

  // Next-state: prescaler, digit index, pending buffer and commit.
  always_comb begin
    pc_d     = tick ? 16'd0 : pc_q + 16'd1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    // Commit looks only at the pending flag from before this edge; a load
    // accepted on the same wrap edge stays pending until the next wrap.
    if (wrap && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end
    if (accept) begin
      pend_d   = bus.value_in;
      pend_v_d = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they switch on the
  // same edge as the digit index.
  always_comb begin
    disp_shift   = disp_d >> {idx_d, 2'b00};
    nibble_d     = disp_shift[3:0];
    an_d         = ~(4'b0001 << idx_d);
    frame_done_d = wrap;
    blank        = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // Shifting down by the digit position leaves nibbles k..3; all zero
    // means this digit is a leading zero.
    blank = (idx_d != 2'd0) && (disp_shift == 16'd0);
`endif
    if (blank) begin
      an_d = 4'b1111;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= 16'd0;
      idx_q        <= 2'd0;
      disp_q       <= 16'd0;
      pend_q       <= 16'd0;
      pend_v_q     <= 1'b0;
      nibble_q     <= 4'd0;
      an_q         <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      nibble_q     <= nibble_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.ready_out      = !pend_v_q;
  assign bus.nibble_out     = nibble_q;
  assign bus.an_out         = an_q;
  assign bus.frame_done_out = frame_done_q;

endmodule

// File: doc/digit_scan_mux.md
# digit_scan_mux

Time-multiplexed 4-digit scan controller that sits directly upstream of the seven-segment decoder. It accepts a 16-bit hex value through a ready/load handshake and holds it in a pending buffer. The buffered value is committed only at a frame boundary, so a frame never shows a mix of old and new digits. Each scan slot drives one 4-bit nibble to the decoder's input together with the matching active-low digit enable.

## Interface
- SCAN_DIV, 4, clock cycles per digit slot; legal range 2..65535; prescaler width 16 bits.
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_in  input  1  load strobe; accepted only when ready_out=1.
- value_in  input  16  hex value; value_in[3:0] is the rightmost digit.
- ready_out  output  1  high when the pending buffer is empty.
- nibble_out  output  4  nibble for the active digit; feeds the seven-segment decoder input.
- an_out  output  4  active-low digit enables; an_out[k] drives digit k.
- frame_done_out  output  1  one-cycle pulse on every frame wrap.

## Operation
- Registers:
  - 16-bit prescaler `pc`.
  - 2-bit digit index `idx`.
  - 16-bit `disp_reg` (displayed value).
  - 16-bit `pend_reg` and 1-bit `pend_v` (pending buffer).
- Prescaler:
  - `pc` counts 0..SCAN_DIV-1 and then wraps to 0.
  - tick = (pc == SCAN_DIV-1).
- Digit index: on tick, `idx` advances 0→1→2→3→0.
- Wrap = tick AND idx==3. On the wrap edge:
  - frame_done_out=1 for that cycle.
  - If `pend_v` was set before the edge: disp_reg←pend_reg, pend_v←0.
- Handshake:
  - ready_out = !pend_v.
  - load_in=1 with ready_out=1 captures value_in into `pend_reg` and sets `pend_v`.
  - load_in while ready_out=0 is ignored; the buffer is not overwritten.
- Simultaneous load and commit on the same wrap edge:
  - The commit uses the old `pend_v`.
  - The new load lands in the pending buffer and commits at the next wrap.
  - No bypass into `disp_reg`.
- Outputs are registered and computed from next-state values, so they change on the same edge as `idx`:
  - nibble_out = disp_reg[4*idx+3 : 4*idx].
  - an_out = ~(1 << idx).
- A new `disp_reg` value appears on nibble_out starting at digit 0 of the following frame.

## Timing
- Reset, asserted asynchronously:
  - pc=0, idx=0, disp_reg=0, pend_reg=0, pend_v=0.
  - ready_out=1, nibble_out=0, an_out=4'b1111 (all digits off), frame_done_out=0.
- First rising edge after rst_n deasserts: an_out=4'b1110, nibble_out=disp_reg[3:0].
- Digit slot length: exactly SCAN_DIV cycles. Frame length: 4·SCAN_DIV cycles.
- Load to visible, worst case: one full frame plus one cycle.
  - ready_out drops on the edge after load_in is accepted.
  - ready_out rises on the edge that performs the commit.
- Reset asserted mid-frame or mid-load: every register returns to its reset value immediately, and any pending value is discarded.
- Wrap-around: idx 3→0 is the only frame boundary. pc never exceeds SCAN_DIV-1.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit k (k=1..3) is blanked, meaning an_out stays 4'b1111 for its slot, when disp_reg nibbles k..3 are all zero.
  - Digit 0 is never blanked, so 0x0000 shows "0".
  - Slot timing and nibble_out values are unchanged.
- Not defined: all four digits are always enabled in turn, and leading zeros are shown.

## Test plan
- Reset check, SCAN_DIV=4: hold rst_n=0 and check an_out=1111, ready_out=1, frame_done_out=0. Release and expect an_out=1110, nibble_out=0 on the first edge.
- Basic load: pulse load_in with value_in=0x1234.
  - ready_out falls next cycle.
  - At the wrap, frame_done_out pulses and ready_out=1.
  - The next frame shows nibble_out 4,3,2,1 with an_out 1110,1101,1011,0111, each held 4 cycles.
- Ignored load: load 0xAAAA, then load 0x5555 while ready_out=0. The next frame displays A,A,A,A; 0x5555 never appears.
- Load on the wrap edge: pending empty, load 0xBEEF in the cycle where tick and idx=3. The display keeps its old value for one more frame, then shows F,E,E,B.
- Blanking with LEADING_ZERO_BLANK_EN: load 0x0050. Slots 2 and 3 give an_out=1111; slots 0 and 1 give 1110 (nibble 0) and 1101 (nibble 5). Without the macro, all four digits enable.
- Reset mid-frame: load 0x9999 while idx=2, then pulse rst_n low. Outputs return to reset values, pend_v clears, and the following frame shows 0,0,0,0.
